div_issue_ctrl: RTL and testbench
=================================

DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 SHALL have parameter: tamanyo, 32, operand/result width in bits.
REQ-002 SHALL have port: CLK  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: IN_VALID  input  1  upstream operand pair valid.
REQ-005 SHALL have port: IN_READY  output  1  block accepts operands.
REQ-006 SHALL have ports: IN_NUM, IN_DEN  input  tamanyo  dividend, divisor.
REQ-007 SHALL have port: START  output  1  one-cycle start pulse to the divider.
REQ-008 SHALL have ports: NUM, DEN  output  tamanyo  registered operands driven to the divider.
REQ-009 SHALL have ports: COC, RES, DONE  input  tamanyo/tamanyo/1  divider quotient, remainder, done.
REQ-010 SHALL have port: OUT_VALID  output  1  result pair valid.
REQ-011 SHALL have port: OUT_READY  input  1  downstream consumes result.
REQ-012 SHALL have ports: OUT_COC, OUT_RES  output  tamanyo  captured quotient, remainder.
REQ-013 SHALL have port: OUT_ERR  output  1  division-by-zero flag for the held result.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, HOLD.
REQ-015 SHALL, in IDLE only, drive IN_READY=1; handshake = IN_VALID and IN_READY high on the same edge.
REQ-016 SHALL, on handshake, register IN_NUM/IN_DEN into NUM/DEN and move to ISSUE.
REQ-017 SHALL drive START=1 for exactly the one cycle spent in ISSUE, then move to WAIT.
REQ-018 SHALL hold NUM/DEN stable from ISSUE until the next handshake.
REQ-019 SHALL, in WAIT, capture COC/RES into OUT_COC/OUT_RES on a DONE rising edge only (DONE=1 and previous-cycle DONE=0), then move to HOLD.
REQ-020 SHALL ignore a DONE level held high from a previous operation, and any DONE edge outside WAIT.
REQ-021 SHALL drive OUT_VALID=1 only in HOLD; OUT_COC/OUT_RES/OUT_ERR stable while OUT_VALID=1 and OUT_READY=0.
REQ-022 SHALL, in HOLD with OUT_READY=1, move to IDLE; next handshake is possible no earlier than the following cycle.
REQ-023 SHALL give latency: handshake at edge N -> START high in cycle N+1 -> OUT_VALID high the cycle after the captured DONE rising edge.
REQ-024 SHALL pass operands unmodified; no width extension or truncation (all paths tamanyo bits).

Reset
REQ-025 SHALL, with RST=1 at a rising edge, enter IDLE and clear START, OUT_VALID, OUT_ERR, NUM, DEN, OUT_COC, OUT_RES and the DONE history register to 0.
REQ-026 SHALL, on reset mid-operation (ISSUE/WAIT/HOLD), abandon the operation; a later divider DONE edge for it is ignored.
REQ-027 SHALL give RST priority over every other event in the same cycle.

Configuration
REQ-028 SHALL use macro DIV_ZERO_CHECK_EN.
REQ-029 SHALL, with DIV_ZERO_CHECK_EN defined, on handshake with IN_DEN=0 go straight to HOLD without START, OUT_COC=all ones, OUT_RES=IN_NUM, OUT_ERR=1.
REQ-030 SHALL, without DIV_ZERO_CHECK_EN, issue DEN=0 to the divider like any other value and tie OUT_ERR to 0.

Structure
REQ-031 SHALL place the FSM state enum typedef and default width constant (32) in shared package div_pkg.
REQ-032 SHALL use one sub-module, done_edge_det (registered DONE, rising-edge pulse output, sync reset).

Verification
REQ-033 SHALL cover: IN_NUM=100, IN_DEN=7, OUT_READY=1 -> one START pulse, OUT_COC=14, OUT_RES=2, OUT_ERR=0.
REQ-034 SHALL cover: IN_NUM=4, IN_DEN=2 -> OUT_COC=2, OUT_RES=0; IN_READY=0 from the accept edge until HOLD exits.
REQ-035 SHALL cover: OUT_READY=0 for 5 cycles in HOLD -> OUT_VALID and OUT_COC/OUT_RES unchanged, IN_READY=0, START=0.
REQ-036 SHALL cover: RST=1 for one cycle during WAIT -> IDLE next cycle, all outputs 0; the divider's later DONE edge produces no OUT_VALID.
REQ-037 SHALL cover: DONE held at 1 across the next START -> no capture until DONE falls and rises again.
REQ-038 SHALL cover: with DIV_ZERO_CHECK_EN, IN_NUM=9, IN_DEN=0 -> START never asserted, OUT_COC=32'hFFFFFFFF, OUT_RES=9, OUT_ERR=1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and width constants for the divider issue controller.
package div_pkg;

  localparam int unsigned DIV_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } div_state_e;

endpackage

// File: rtl/done_edge_det.sv
// Rising-edge detector for the divider DONE level; the history register is cleared by reset.
module done_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic done,
  output logic rise_c
);

  logic done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done;
    end
  end

  assign rise_c = done & ~done_q;

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/collect controller between a valid/ready operand stream and a multi-cycle divider.
// Optional feature: DIV_ZERO_CHECK_EN short-circuits a zero divisor straight to an error result.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int unsigned tamanyo = DIV_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [tamanyo-1:0] IN_NUM,
  input  logic [tamanyo-1:0] IN_DEN,
  output logic               START,
  output logic [tamanyo-1:0] NUM,
  output logic [tamanyo-1:0] DEN,
  input  logic [tamanyo-1:0] COC,
  input  logic [tamanyo-1:0] RES,
  input  logic               DONE,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [tamanyo-1:0] OUT_COC,
  output logic [tamanyo-1:0] OUT_RES,
  output logic               OUT_ERR
);

  div_state_e state_q;
  div_state_e state_d;
  logic       in_ready_d;
  logic       start_d;
  logic       out_valid_d;
  logic       hs;
  logic       zero_den;
  logic       done_rise_c;
  logic       capture;

  done_edge_det u_done_edge_det (
    .clk    (CLK),
    .rst    (RST),
    .done   (DONE),
    .rise_c (done_rise_c)
  );

  assign hs      = IN_VALID && (state_q == IDLE);
  assign capture = (state_q == WAIT) && done_rise_c;

`ifdef DIV_ZERO_CHECK_EN
  assign zero_den = (IN_DEN == '0);
`else
  assign zero_den = 1'b0;
`endif

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hs) state_d = zero_den ? HOLD : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (done_rise_c) state_d = HOLD;
      HOLD:    if (OUT_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    start_d     = (state_d == ISSUE);
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      IN_READY  <= 1'b1;
      START     <= 1'b0;
      OUT_VALID <= 1'b0;
    end else begin
      state_q   <= state_d;
      IN_READY  <= in_ready_d;
      START     <= start_d;
      OUT_VALID <= out_valid_d;
    end
  end

  // Operands stay put from accept until the next accept
  always_ff @(posedge CLK) begin
    if (RST) begin
      NUM <= '0;
      DEN <= '0;
    end else if (hs) begin
      NUM <= IN_NUM;
      DEN <= IN_DEN;
    end
  end

`ifdef DIV_ZERO_CHECK_EN
  logic err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_COC <= '0;
      OUT_RES <= '0;
      err_q   <= 1'b0;
    end else if (hs && zero_den) begin
      OUT_COC <= '1;
      OUT_RES <= IN_NUM;
      err_q   <= 1'b1;
    end else if (capture) begin
      OUT_COC <= COC;
      OUT_RES <= RES;
      err_q   <= 1'b0;
    end
  end

  assign OUT_ERR = err_q;
`else
  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_COC <= '0;
      OUT_RES <= '0;
    end else if (capture) begin
      OUT_COC <= COC;
      OUT_RES <= RES;
    end
  end

  assign OUT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: a behavioural divider stand-in plus a plain-arithmetic result model.
module tb_div_issue_ctrl;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_num;
  logic [W-1:0] in_den;
  logic         start;
  logic [W-1:0] num;
  logic [W-1:0] den;
  logic [W-1:0] coc;
  logic [W-1:0] res;
  logic         done;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_coc;
  logic [W-1:0] out_res;
  logic         out_err;

  int tests     = 0;
  int fails     = 0;
  int start_cnt = 0;

  div_issue_ctrl #(.tamanyo(W)) dut (
    .CLK       (clk),
    .RST       (rst),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .IN_NUM    (in_num),
    .IN_DEN    (in_den),
    .START     (start),
    .NUM       (num),
    .DEN       (den),
    .COC       (coc),
    .RES       (res),
    .DONE      (done),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .OUT_COC   (out_coc),
    .OUT_RES   (out_res),
    .OUT_ERR   (out_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (start === 1'b1) start_cnt++;

  // One full transaction; inputs change and outputs are checked on the falling edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                        input int hold, input bit keep_done);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    bit           zpath;
    zpath = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
    zpath = (b == '0);
`endif
    eq = (b == '0) ? '1 : a / b;
    er = (b == '0) ? a : a % b;
    start_cnt = 0;

    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL idle_ready: got %b exp 1", in_ready);
    end
    in_valid = 1'b1; in_num = a; in_den = b;
    @(negedge clk);
    in_valid = 1'b0; in_num = $urandom; in_den = $urandom;
    tests++;
    if ({in_ready, num, den} !== {1'b0, a, b}) begin
      fails++; $display("FAIL accept: got rdy=%b num=%h den=%h exp rdy=0 num=%h den=%h",
                        in_ready, num, den, a, b);
    end

    if (zpath) begin
      tests++;
      if ({start, out_valid, out_coc, out_res, out_err} !== {1'b0, 1'b1, eq, er, 1'b1}) begin
        fails++; $display("FAIL zero_den: got st=%b v=%b q=%h r=%h e=%b exp st=0 v=1 q=%h r=%h e=1",
                          start, out_valid, out_coc, out_res, out_err, eq, er);
      end
    end else begin
      tests++;
      if ({start, out_valid} !== 2'b10) begin
        fails++; $display("FAIL issue: got st=%b v=%b exp st=1 v=0", start, out_valid);
      end
      if (done) begin
        repeat (3) begin
          @(negedge clk);
          tests++;
          if (out_valid !== 1'b0) begin
            fails++; $display("FAIL held_done: got v=%b exp 0", out_valid);
          end
        end
        done = 1'b0;
      end
      repeat (lat) @(negedge clk);
      tests++;
      if ({start, in_ready, out_valid} !== 3'b000) begin
        fails++; $display("FAIL wait: got st=%b rdy=%b v=%b exp 000", start, in_ready, out_valid);
      end
      // Divider stand-in answers from the operands it was handed
      coc  = (den == '0) ? '1 : num / den;
      res  = (den == '0) ? num : num % den;
      done = 1'b1;
      @(negedge clk);
      if (!keep_done) done = 1'b0;
      coc = $urandom; res = $urandom;
      tests++;
      if ({out_valid, out_coc, out_res, out_err} !== {1'b1, eq, er, 1'b0}) begin
        fails++; $display("FAIL capture: got v=%b q=%h r=%h e=%b exp v=1 q=%h r=%h e=0",
                          out_valid, out_coc, out_res, out_err, eq, er);
      end
    end

    repeat (hold) begin
      @(negedge clk);
      tests++;
      if ({out_valid, in_ready, start, out_coc, out_res, out_err} !== {3'b100, eq, er, zpath}) begin
        fails++; $display("FAIL hold: got v=%b rdy=%b st=%b q=%h r=%h e=%b exp v=1 rdy=0 st=0 q=%h r=%h e=%b",
                          out_valid, in_ready, start, out_coc, out_res, out_err, eq, er, zpath);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++; $display("FAIL release: got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
    end
    tests++;
    if (start_cnt !== (zpath ? 0 : 1)) begin
      fails++; $display("FAIL start_count: got %0d exp %0d", start_cnt, zpath ? 0 : 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_num = 32'd55; in_den = 32'd5;
    out_ready = 1'b0; done = 1'b0; coc = '0; res = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    tests++;
    if ({in_ready, start, out_valid, out_err, num, den, out_coc, out_res} !== {4'b1000, 128'd0}) begin
      fails++; $display("FAIL reset: got rdy=%b st=%b v=%b e=%b num=%h den=%h q=%h r=%h",
                        in_ready, start, out_valid, out_err, num, den, out_coc, out_res);
    end
  endtask

  task automatic test_basic();
    run_op(32'd100, 32'd7, 2, 0, 1'b0);
    run_op(32'd4, 32'd2, 1, 0, 1'b0);
  endtask

  task automatic test_hold();
    run_op($urandom, 32'($urandom_range(1, 1000)), 3, 5, 1'b0);
  endtask

  task automatic test_reset_in_wait();
    done = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_num = 32'd1234; in_den = 32'd10;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({in_ready, start, out_valid, out_err, num, den, out_coc, out_res} !== {4'b1000, 128'd0}) begin
      fails++; $display("FAIL reset_wait: got rdy=%b st=%b v=%b e=%b num=%h den=%h q=%h r=%h",
                        in_ready, start, out_valid, out_err, num, den, out_coc, out_res);
    end
    coc = 32'd123; res = 32'd4; done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if ({out_valid, in_ready, out_coc} !== {2'b01, 32'd0}) begin
        fails++; $display("FAIL stale_done: got v=%b rdy=%b q=%h exp v=0 rdy=1 q=0",
                          out_valid, in_ready, out_coc);
      end
    end
    done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_done_held();
    run_op(32'd77, 32'd3, 2, 1, 1'b1);
    run_op(32'd500, 32'd9, 2, 0, 1'b0);
  endtask

  task automatic test_div_zero();
    run_op(32'd9, 32'd0, 2, 2, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 16));
        2:       b = 32'($urandom_range(1, 65535));
        default: b = $urandom;
      endcase
      run_op(a, b, $urandom_range(1, 5), $urandom_range(0, 4), ($urandom_range(0, 3) == 0));
    end
    done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_reset_in_wait();
    test_done_held();
    test_div_zero();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
